// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: S RAM geometry, key length default and KSA state encoding.
package rc4_pkg;

   localparam int unsigned S_SIZE            = 256;
   localparam int unsigned KEY_BYTES_DEFAULT = 3;
   localparam int unsigned S_RD_LATENCY      = 1;

   typedef enum logic [3:0] {
      StIdle,
      StFill,
      StRdI,
      StLatchSi,
      StRdJ,
      StLatchSj,
      StWrI,
      StWrJ,
      StDone
   } ksa_state_t;

endpackage

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling: fills S with the identity permutation, then scrambles it with the key.
// Owns the single-port S RAM while busy; done hands control to the decrypt FSM.
module rc4_ksa
   import rc4_pkg::*;
#(
   parameter int unsigned KEY_BYTES = KEY_BYTES_DEFAULT
) (
   input  logic                   clock,
   input  logic                   i_reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] key,
   input  logic [7:0]             s_q,
   output logic [7:0]             s_address,
   output logic [7:0]             s_data,
   output logic                   s_wren,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned KEY_W     = 8 * KEY_BYTES;
   localparam int unsigned KIDX_W    = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam int unsigned KLSB_W    = $clog2(KEY_W);
   localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(KEY_BYTES - 1);
   localparam logic [7:0]        I_LAST    = 8'(S_SIZE - 1);

   ksa_state_t        state_q, state_d;
   logic [7:0]        i_q, i_d;
   logic [7:0]        j_q, j_d;
   logic [7:0]        si_q, si_d;
   logic [7:0]        sj_q, sj_d;
   logic [KIDX_W-1:0] kidx_q, kidx_d;
   logic [KEY_W-1:0]  key_q, key_d;

   logic [KLSB_W-1:0] key_lsb;
   logic [7:0]        key_byte;

   // Key byte 0 sits in the most significant byte of the key word.
   assign key_lsb  = KLSB_W'(8 * (KEY_BYTES - 1 - int'(kidx_q)));
   assign key_byte = key_q[key_lsb +: 8];

   always_ff @(posedge clock) begin
      if (i_reset) begin
         state_q <= StIdle;
         i_q     <= '0;
         j_q     <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         kidx_q  <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         kidx_q  <= kidx_d;
         key_q   <= key_d;
      end
   end

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;
      key_d   = key_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StFill;
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               key_d   = key;
            end
         end
         StFill: begin
            if (i_q == I_LAST) begin
               state_d = StRdI;
               i_d     = '0;
               kidx_d  = '0;
            end else begin
               i_d = i_q + 8'd1;
            end
         end
         StRdI:     state_d = StLatchSi;
         StLatchSi: begin
            si_d    = s_q;
            j_d     = j_q + s_q + key_byte;
            state_d = StRdJ;
         end
         StRdJ:     state_d = StLatchSj;
         StLatchSj: begin
            sj_d    = s_q;
            state_d = StWrI;
         end
         StWrI:     state_d = StWrJ;
         StWrJ: begin
            i_d     = i_q + 8'd1;
            kidx_d  = (kidx_q == KIDX_LAST) ? '0 : kidx_q + KIDX_W'(1);
            state_d = (i_q == I_LAST) ? StDone : StRdI;
         end
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_comb begin
      s_address = '0;
      s_data    = '0;
      s_wren    = 1'b0;
      unique case (state_q)
         StFill: begin
            s_address = i_q;
            s_data    = i_q;
            s_wren    = 1'b1;
         end
         StRdI:  s_address = i_q;
         StRdJ:  s_address = j_q;
         StWrI: begin
            s_address = i_q;
            s_data    = sj_q;
            s_wren    = 1'b1;
         end
         StWrJ: begin
            s_address = j_q;
            s_data    = si_q;
            s_wren    = 1'b1;
         end
         default: ;
      endcase
   end

   assign busy = (state_q != StIdle);
   assign done = (state_q == StDone);

endmodule
